mem_access_stage: RTL and testbench

- MEM stage of the 16-bit pipelined datapath: the producer that feeds the MEM/WB pipe register.
- Takes EX/MEM fields and runs loads and stores against a variable-latency data memory using a req/ack handshake.
- Stalls the upstream pipe while an access is outstanding.
- Delivers registered alu_result, mem_result, wb_enable, mem_rd_mux, pc_en and a valid qualifier for writeback.

---
 rtl/mem_access_stage_pkg.sv | 6 +
 rtl/mem_access_stage_watchdog.sv | 29 ++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and defaults for the MEM stage of the 16-bit datapath.
package mem_access_stage_pkg;
  typedef enum logic {MS_IDLE, MS_ACCESS} mem_state_t;
  localparam int ARQ_DEF     = 16;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_access_stage_watchdog.sv
// ACCESS-cycle counter; flags expiry on the TIMEOUT-th cycle without ack.
module mem_watchdog
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expire
);
  localparam int CW = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of ack-less ACCESS cycles already elapsed
  always_comb begin
    cnt_d = '0;
    if (active && !ack) cnt_d = cnt_q + 1'b1;
  end

  assign expire = active & ~ack & (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over a req/ack data memory port and feeds MEM/WB.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ARQ     = ARQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           mem_rd_in,
  input  logic           mem_wr_in,
  input  logic           wb_enable_in,
  input  logic           pc_en_in,
  input  logic [ARQ-1:0] alu_result_in,
  input  logic [ARQ-1:0] store_data_in,
  output logic           stall_out,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [ARQ-1:0] dmem_addr,
  output logic [ARQ-1:0] dmem_wdata,
  input  logic           dmem_ack,
  input  logic [ARQ-1:0] dmem_rdata,
  output logic           out_valid,
  output logic           mem_rd_mux_out,
  output logic           wb_enable_out,
  output logic           pc_en_out,
  output logic [ARQ-1:0] alu_result_out,
  output logic [ARQ-1:0] mem_result_out,
  output logic           err_out
);
  mem_state_t     state_q, state_d;
  logic           req_q, req_d, we_q, we_d;
  logic [ARQ-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic           cap_rd_q, cap_rd_d, cap_wb_q, cap_wb_d, cap_pc_q, cap_pc_d;
  logic           ov_q, ov_d, mux_q, mux_d, wb_q, wb_d, pc_q, pc_d, err_q, err_d;
  logic [ARQ-1:0] alu_q, alu_d, res_q, res_d;
  logic           in_access, expire;

  assign in_access = (state_q == MS_ACCESS);

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (in_access),
    .ack    (dmem_ack),
    .expire (expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT;
  assign expire     = 1'b0;
`endif

  // A timed-out access releases upstream just like a completed one
  assign stall_out = ~rst & in_valid & (mem_rd_in | mem_wr_in)
                   & ~(in_access & (dmem_ack | expire));

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cap_rd_d = cap_rd_q;
    cap_wb_d = cap_wb_q;
    cap_pc_d = cap_pc_q;
    ov_d     = 1'b0;
    mux_d    = 1'b0;
    wb_d     = 1'b0;
    pc_d     = 1'b0;
    err_d    = 1'b0;
    alu_d    = '0;
    res_d    = '0;
    case (state_q)
      MS_IDLE: begin
        if (in_valid) begin
          if (mem_rd_in || mem_wr_in) begin
            state_d  = MS_ACCESS;
            req_d    = 1'b1;
            we_d     = mem_wr_in & ~mem_rd_in;
            addr_d   = alu_result_in;
            wdata_d  = store_data_in;
            cap_rd_d = mem_rd_in;
            cap_wb_d = wb_enable_in;
            cap_pc_d = pc_en_in;
          end else begin
            ov_d  = 1'b1;
            alu_d = alu_result_in;
            wb_d  = wb_enable_in;
            pc_d  = pc_en_in;
          end
        end
      end
      MS_ACCESS: begin
        if (dmem_ack) begin
          state_d = MS_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ov_d    = 1'b1;
          alu_d   = addr_q;
          wb_d    = cap_wb_q;
          pc_d    = cap_pc_q;
          mux_d   = cap_rd_q;
          res_d   = cap_rd_q ? dmem_rdata : '0;
        end else if (expire) begin
          state_d = MS_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ov_d    = 1'b1;
          alu_d   = addr_q;
          pc_d    = cap_pc_q;
          err_d   = 1'b1;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MS_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_rd_q <= 1'b0;
      cap_wb_q <= 1'b0;
      cap_pc_q <= 1'b0;
      ov_q     <= 1'b0;
      mux_q    <= 1'b0;
      wb_q     <= 1'b0;
      pc_q     <= 1'b0;
      err_q    <= 1'b0;
      alu_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cap_rd_q <= cap_rd_d;
      cap_wb_q <= cap_wb_d;
      cap_pc_q <= cap_pc_d;
      ov_q     <= ov_d;
      mux_q    <= mux_d;
      wb_q     <= wb_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      alu_q    <= alu_d;
      res_q    <= res_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign out_valid      = ov_q;
  assign mem_rd_mux_out = mux_q;
  assign wb_enable_out  = wb_q;
  assign pc_en_out      = pc_q;
  assign alu_result_out = alu_q;
  assign mem_result_out = res_q;
  assign err_out        = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; timeout cases run when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;
  localparam int ARQ = 16;

  logic           clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic           in_valid = 0, mem_rd_in = 0, mem_wr_in = 0, wb_enable_in = 0, pc_en_in = 0;
  logic [ARQ-1:0] alu_result_in = '0, store_data_in = '0, dmem_rdata = '0;
  logic           dmem_ack = 0;
  logic           stall_out, dmem_req, dmem_we, out_valid, mem_rd_mux_out;
  logic           wb_enable_out, pc_en_out, err_out;
  logic [ARQ-1:0] dmem_addr, dmem_wdata, alu_result_out, mem_result_out;
  int             checks = 0, failures = 0;

  mem_access_stage #(.ARQ(ARQ), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .wb_enable_in(wb_enable_in), .pc_en_in(pc_en_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .mem_rd_mux_out(mem_rd_mux_out),
    .wb_enable_out(wb_enable_out), .pc_en_out(pc_en_out),
    .alu_result_out(alu_result_out), .mem_result_out(mem_result_out), .err_out(err_out)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic wb,
                       input logic pc, input logic [ARQ-1:0] a, input logic [ARQ-1:0] d);
    in_valid = v; mem_rd_in = rd; mem_wr_in = wr; wb_enable_in = wb;
    pc_en_in = pc; alu_result_in = a; store_data_in = d;
  endtask

  initial begin
    // reset with the clock stopped
    drive(1, 1, 0, 1, 1, 16'h7777, 16'h0);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_alu", alu_result_out, 0);
    chk("rst_err", err_out, 0);
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    clk_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_bubble_valid", out_valid, 0);
    chk("idle_bubble_wb", wb_enable_out, 0);

    // ALU op
    drive(1, 0, 0, 1, 1, 16'h1234, 16'h0);
    #1 chk("alu_stall", stall_out, 0);
    step();
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("alu_valid", out_valid, 1);
    chk("alu_result", alu_result_out, 16'h1234);
    chk("alu_wb", wb_enable_out, 1);
    chk("alu_pc", pc_en_out, 1);
    chk("alu_mux", mem_rd_mux_out, 0);
    chk("alu_memres", mem_result_out, 0);

    // load at 0x0040, ack in third ACCESS cycle
    drive(1, 1, 0, 1, 1, 16'h0040, 16'h0);
    #1 chk("ld_stall_idle", stall_out, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("ld_req_c%0d", i), dmem_req, 1);
      chk($sformatf("ld_bubble_c%0d", i), out_valid, 0);
      if (i < 3) chk($sformatf("ld_stall_c%0d", i), stall_out, 1);
    end
    chk("ld_addr", dmem_addr, 16'h0040);
    chk("ld_we", dmem_we, 0);
    dmem_ack = 1; dmem_rdata = 16'hBEEF;
    #1 chk("ld_stall_ack", stall_out, 0);
    step();
    dmem_ack = 0; dmem_rdata = 16'h0;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("ld_valid", out_valid, 1);
    chk("ld_mux", mem_rd_mux_out, 1);
    chk("ld_memres", mem_result_out, 16'hBEEF);
    chk("ld_alu", alu_result_out, 16'h0040);
    chk("ld_req_drop", dmem_req, 0);

    // store 0x00AA to 0x0010, ack in first ACCESS cycle, then an ALU op
    drive(1, 0, 1, 0, 1, 16'h0010, 16'h00AA);
    step();
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 16'h00AA);
    chk("st_addr", dmem_addr, 16'h0010);
    chk("st_bubble", out_valid, 0);
    dmem_ack = 1;
    #1 chk("st_stall_ack", stall_out, 0);
    step();
    dmem_ack = 0;
    drive(1, 0, 0, 1, 0, 16'h5555, 16'h0);
    chk("st_valid", out_valid, 1);
    chk("st_memres", mem_result_out, 0);
    chk("st_mux", mem_rd_mux_out, 0);
    chk("st_we_drop", dmem_we, 0);
    step();
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("st_next_alu_valid", out_valid, 1);
    chk("st_next_alu", alu_result_out, 16'h5555);

    // rd and wr together behave as a load
    drive(1, 1, 1, 1, 0, 16'h0080, 16'h1111);
    step();
    chk("rw_we", dmem_we, 0);
    chk("rw_req", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 16'hCAFE;
    step();
    dmem_ack = 0;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("rw_mux", mem_rd_mux_out, 1);
    chk("rw_memres", mem_result_out, 16'hCAFE);

    // reset in the middle of an access, then a stray ack
    drive(1, 1, 0, 1, 0, 16'h0090, 16'h0);
    step(); step();
    chk("mid_req", dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall_out, 0);
    chk("mid_rst_valid", out_valid, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    dmem_ack = 1; dmem_rdata = 16'hDEAD;
    step();
    dmem_ack = 0;
    chk("stray_ack_valid", out_valid, 0);
    chk("stray_ack_req", dmem_req, 0);
    chk("stray_ack_memres", mem_result_out, 0);

`ifdef MEM_TIMEOUT_EN
    // no ack: expiry on the fourth ACCESS cycle
    drive(1, 1, 0, 1, 0, 16'h00A0, 16'h0);
    for (int i = 1; i <= 4; i++) step();
    chk("to_req_c4", dmem_req, 1);
    chk("to_stall_release", stall_out, 0);
    step();
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("to_err", err_out, 1);
    chk("to_valid", out_valid, 1);
    chk("to_wb", wb_enable_out, 0);
    chk("to_mux", mem_rd_mux_out, 0);
    chk("to_req_drop", dmem_req, 0);
    step();
    chk("to_err_pulse", err_out, 0);
    // ack on the fourth cycle wins
    drive(1, 1, 0, 1, 0, 16'h00B0, 16'h0);
    for (int i = 1; i <= 4; i++) step();
    dmem_ack = 1; dmem_rdata = 16'h1111;
    step();
    dmem_ack = 0;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("to_ack_err", err_out, 0);
    chk("to_ack_wb", wb_enable_out, 1);
    chk("to_ack_memres", mem_result_out, 16'h1111);
`else
    // without the watchdog an access waits past any TIMEOUT
    drive(1, 1, 0, 1, 0, 16'h00A0, 16'h0);
    for (int i = 1; i <= 6; i++) step();
    chk("nto_req", dmem_req, 1);
    chk("nto_stall", stall_out, 1);
    chk("nto_err", err_out, 0);
    dmem_ack = 1; dmem_rdata = 16'h2222;
    step();
    dmem_ack = 0;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("nto_memres", mem_result_out, 16'h2222);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
